decoder_scanner: RTL and testbench

- Parametrised registered one-hot decoder and the successor of the team's fixed 3-to-8 combinational translator.
- Mode 0 (DIRECT) registers the decode of a binary address.
- Mode 1 (SCAN) steps the active output from a start address to the top, holding each output for a programmable number of cycles, with optional wrap-around.
- Drives strobe and select lines for banked peripherals and LED or test sequencing.

---
 rtl/decoder_scanner_pkg.sv | 21 ++
 rtl/decoder_scanner_if.sv | 26 ++
 rtl/decoder_scanner_dwell_counter.sv | 30 +++
 rtl/decoder_scanner.sv | 138 +++++++++++++
 tb/tb_decoder_scanner.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/decoder_scanner_pkg.sv
// Shared types and the one-hot helper for the registered decoder/scanner.
// The helper is sized for the widest supported address; callers truncate.
package decoder_pkg;

    localparam int unsigned MAX_AW = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic logic [2**MAX_AW-1:0] onehot(input logic [MAX_AW-1:0] index);
        onehot        = '0;
        onehot[index] = 1'b1;
    endfunction

endpackage

// File: rtl/decoder_scanner_if.sv
// Control/status bundle between the decoder/scanner and its driver.
interface decoder_scanner_if #(
    parameter int unsigned AW = 3
);
    logic              en;
    logic              mode;
    logic              start;
    logic              stop;
    logic              wrap;
    logic [AW-1:0]     addr;
    logic [2**AW-1:0]  d;
    logic [AW-1:0]     idx;
    logic              valid;
    logic              busy;
    logic              done;

    modport master (
        output en, mode, start, stop, wrap, addr,
        input  d, idx, valid, busy, done
    );

    modport slave (
        input  en, mode, start, stop, wrap, addr,
        output d, idx, valid, busy, done
    );
endinterface

// File: rtl/decoder_scanner_dwell_counter.sv
// Counts enabled cycles spent on one scan index; last marks the final one.
module dwell_counter #(
    parameter int unsigned DWELL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic last
);
    localparam int unsigned CW = $clog2(DWELL + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign last = (cnt_q == CW'(DWELL));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = CW'(1);
        end else if (tick) begin
            cnt_d = last ? CW'(1) : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/decoder_scanner.sv
// Registered one-hot decoder with a DIRECT mode and a dwell-timed SCAN mode.
module decoder_scanner
    import decoder_pkg::*;
#(
    parameter int unsigned AW         = 3,
    parameter int unsigned DWELL      = 1,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst,
    decoder_scanner_if.slave  bus
);
    localparam int unsigned N = 2**AW;
    localparam logic [N-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

    state_t        state_q, state_d;
    logic [N-1:0]  d_q, d_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          cnt_clear, cnt_tick, cnt_last;
    logic [AW-1:0] idx_inc;

    // Polarity is folded in here so d_q already holds the pin-level value.
    function automatic logic [N-1:0] decode(input logic [AW-1:0] x);
        decode = INACTIVE ^ N'(onehot(MAX_AW'(x)));
    endfunction

    assign idx_inc = idx_q + AW'(1);

    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .tick  (cnt_tick),
        .last  (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        d_d       = d_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_clear = 1'b0;
        cnt_tick  = 1'b0;
        case (state_q)
            IDLE: begin
                d_d     = INACTIVE;
                idx_d   = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (bus.en && bus.mode == MODE_DIRECT) begin
                    state_d = DIRECT;
                    d_d     = decode(bus.addr);
                    idx_d   = bus.addr;
                    valid_d = 1'b1;
                end else if (bus.en && bus.mode == MODE_SCAN && bus.start && !done_q) begin
                    state_d   = SCAN;
                    d_d       = decode(bus.addr);
                    idx_d     = bus.addr;
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                    cnt_clear = 1'b1;
                end
            end
            DIRECT: begin
                if (bus.en) begin
                    d_d     = decode(bus.addr);
                    idx_d   = bus.addr;
                    valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    d_d     = INACTIVE;
                    idx_d   = '0;
                    valid_d = 1'b0;
                end
            end
            SCAN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    d_d     = INACTIVE;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (bus.en) begin
                    cnt_tick = 1'b1;
                    if (cnt_last) begin
                        if (idx_q == '1 && !bus.wrap) begin
                            state_d = IDLE;
                            d_d     = INACTIVE;
                            idx_d   = '0;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_inc;
                            d_d   = decode(idx_inc);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                d_d     = INACTIVE;
                idx_d   = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            d_q     <= INACTIVE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.d     = d_q;
    assign bus.idx   = idx_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_decoder_scanner.sv
// Directed bench for decoder_scanner: DIRECT, scan with/without wrap, pause,
// stop, mid-scan reset and the active-low output polarity.
module tb_decoder_scanner;
    import decoder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    decoder_scanner_if #(.AW(3)) bus ();
    decoder_scanner_if #(.AW(3)) bus_al ();

    decoder_scanner #(.AW(3), .DWELL(2), .ACTIVE_LOW(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    decoder_scanner #(.AW(3), .DWELL(2), .ACTIVE_LOW(1)) dut_al (
        .clk (clk),
        .rst (rst),
        .bus (bus_al)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ed, input logic [2:0] ei,
                           input logic ev, input logic eb, input logic edn);
        chk({tag, ".d"},     64'(bus.d),     64'(ed));
        chk({tag, ".idx"},   64'(bus.idx),   64'(ei));
        chk({tag, ".valid"}, 64'(bus.valid), 64'(ev));
        chk({tag, ".busy"},  64'(bus.busy),  64'(eb));
        chk({tag, ".done"},  64'(bus.done),  64'(edn));
    endtask

    initial begin
        logic [7:0] exp_d;
        logic [7:0] scan_exp [6];
        scan_exp = '{8'h20, 8'h20, 8'h40, 8'h40, 8'h80, 8'h80};

        {bus.en, bus.mode, bus.start, bus.stop, bus.wrap} = '0;
        bus.addr = '0;
        {bus_al.en, bus_al.mode, bus_al.start, bus_al.stop, bus_al.wrap} = '0;
        bus_al.addr = '0;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("reset_al.d", 64'(bus_al.d), 64'hFF);

        // DIRECT sweep
        bus.mode = MODE_DIRECT;
        bus.en   = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus.addr = 3'(a);
            tick();
            exp_d = 8'h01 << a;
            chk_out($sformatf("direct%0d", a), exp_d, 3'(a), 1'b1, 1'b0, 1'b0);
        end

        // DIRECT disable
        bus.en = 1'b0;
        tick();
        chk_out("direct_off", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("idle_hold", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        // Non-wrapping scan from 5; addr changes after start are ignored
        bus.mode  = MODE_SCAN;
        bus.en    = 1'b1;
        bus.addr  = 3'd5;
        bus.wrap  = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.addr  = 3'd0;
        chk_out("scan0", scan_exp[0], 3'd5, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 6; i++) begin
            tick();
            chk($sformatf("scan%0d.d", i), 64'(bus.d), 64'(scan_exp[i]));
            chk($sformatf("scan%0d.busy", i), 64'(bus.busy), 64'd1);
        end
        tick();
        chk_out("scan_done", 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);

        // Start coincident with done is ignored, accepted one cycle later
        bus.addr  = 3'd6;
        bus.wrap  = 1'b1;
        bus.start = 1'b1;
        tick();
        chk_out("start_on_done", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.start = 1'b0;
        chk_out("wrap_start", 8'h40, 3'd6, 1'b1, 1'b1, 1'b0);
        tick();
        chk("wrap1.d", 64'(bus.d), 64'h40);
        tick();
        chk("wrap2.d", 64'(bus.d), 64'h80);
        tick();
        chk("wrap3.d", 64'(bus.d), 64'h80);
        tick();
        chk_out("wrap_to0", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);

        // Pause for three cycles
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("pause%0d", i), 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
        end
        bus.en = 1'b1;
        tick();
        chk("resume.d", 64'(bus.d), 64'h01);
        tick();
        chk_out("resume_step", 8'h02, 3'd1, 1'b1, 1'b1, 1'b0);

        // start/mode/addr while busy are ignored
        bus.start = 1'b1;
        bus.mode  = MODE_DIRECT;
        bus.addr  = 3'd7;
        tick();
        chk_out("busy_ign0", 8'h02, 3'd1, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("busy_ign1", 8'h04, 3'd2, 1'b1, 1'b1, 1'b0);

        // Stop while d = 04
        bus.stop = 1'b1;
        tick();
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        bus.mode  = MODE_SCAN;
        chk_out("stop", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("stop_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        // Reset mid-scan
        bus.addr  = 3'd3;
        bus.wrap  = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_out("rscan0", 8'h08, 3'd3, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        chk_out("rscan2", 8'h10, 3'd4, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        bus.en = 1'b0;
        chk_out("mid_reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("mid_reset_al.d", 64'(bus_al.d), 64'hFF);

        // Active-low DIRECT
        bus_al.mode = MODE_DIRECT;
        bus_al.en   = 1'b1;
        bus_al.addr = 3'd2;
        tick();
        chk("al_direct.d", 64'(bus_al.d), 64'hFB);
        chk("al_direct.valid", 64'(bus_al.valid), 64'd1);
        chk("al_direct.idx", 64'(bus_al.idx), 64'd2);
        bus_al.en = 1'b0;
        tick();
        chk("al_off.d", 64'(bus_al.d), 64'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
